// File: rtl/scroll_status_sequencer_pkg.sv
// Shared definitions for the scroll status sequencer: default widths, gate status codes, FSM states.
package scroll_status_sequencer_pkg;

    localparam int unsigned DEF_STATUS_W   = 3;
    localparam int unsigned DEF_POS_W      = 5;
    localparam int unsigned DEF_NUM_DIGITS = 4;

    // Gate status codes shared with the lock FSM and the gate driver
    localparam logic [DEF_STATUS_W-1:0] GATE_OPEN   = 3'd1;
    localparam logic [DEF_STATUS_W-1:0] GATE_LOCKED = 3'd2;
    localparam logic [DEF_STATUS_W-1:0] GATE_ALARM  = 3'd3;

    // Sequencer states; PUBLISH lasts exactly one cycle
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCROLL  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_PUBLISH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/scroll_status_sequencer_timer.sv
// Tick-enabled up counter with synchronous clear and a terminal-count flag.
module scroll_hold_timer #(
    parameter int unsigned W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W:0]   i_terminal,
    output logic [W-1:0] o_count,
    output logic         o_tc_c
);

    logic [W-1:0] r_count;

    // Counter: clear wins over increment
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    // Terminal compare one bit wider so a terminal value beyond the counter range never aliases
    assign o_tc_c  = ({1'b0, r_count} == i_terminal);

endmodule

// File: rtl/scroll_status_sequencer.sv
// Sequences scrolling-message passes and a blank hold, then publishes the final gate status.
module scroll_status_sequencer
    import scroll_status_sequencer_pkg::*;
#(
    parameter int unsigned          STATUS_W     = DEF_STATUS_W,
    parameter int unsigned          POS_W        = DEF_POS_W,
    parameter int unsigned          NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned          PASSES       = 1,
    parameter int unsigned          HOLD_TICKS   = 8,
    parameter int unsigned          PASS_THROUGH = 0,
    parameter logic [STATUS_W-1:0]  FINAL_STATUS = GATE_LOCKED,
    parameter int unsigned          RESTART_EN   = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_scroll_tick,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [STATUS_W-1:0] i_temp_gate_status,
    input  logic [POS_W-1:0]    i_msg_len,
    output logic [POS_W-1:0]    o_scroll_pos,
    output logic                o_scrolling,
    output logic                o_busy,
    output logic                o_done,
    output logic [STATUS_W-1:0] o_finished_gate_status,
    output logic                o_status_valid
);

    localparam int unsigned PASS_W = $clog2(PASSES + 1);
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
    localparam logic [HOLD_W:0]   HOLD_LAST = (HOLD_TICKS == 0) ? '0 : (HOLD_W + 1)'(HOLD_TICKS - 1);

    seq_state_e          r_state;
    seq_state_e          w_state_next;
    logic [STATUS_W-1:0] r_stat;
    logic [POS_W-1:0]    r_len;
    logic [PASS_W-1:0]   r_pass_cnt;
    logic                r_done;
    logic [STATUS_W-1:0] r_fin;
    logic                r_valid;
    logic                r_scrolling;
    logic                r_busy;

    logic                w_latch;
    logic                w_pos_clr;
    logic                w_pos_en;
    logic                w_hold_clr;
    logic                w_hold_en;
    logic                w_pass_clr;
    logic                w_pass_inc;
    logic                w_publish;
    logic [POS_W:0]      w_pos_last;
    logic                w_pos_tc;
    logic                w_hold_tc;
    logic [POS_W-1:0]    w_pos;
    logic [HOLD_W-1:0]   w_hold_cnt_unused;

    // Last scroll offset of a pass, computed one bit wide so msg_len+NUM_DIGITS cannot wrap
    assign w_pos_last = {1'b0, r_len} + (POS_W + 1)'(NUM_DIGITS) - (POS_W + 1)'(1);

    // Scroll position counter
    scroll_hold_timer #(
        .W (POS_W)
    ) u_pos_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_pos_clr),
        .i_en       (w_pos_en),
        .i_terminal (w_pos_last),
        .o_count    (w_pos),
        .o_tc_c     (w_pos_tc)
    );

    // Blank hold counter
    scroll_hold_timer #(
        .W (HOLD_W)
    ) u_hold_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_hold_clr),
        .i_en       (w_hold_en),
        .i_terminal (HOLD_LAST),
        .o_count    (w_hold_cnt_unused),
        .o_tc_c     (w_hold_tc)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control; priority abort > start > scroll_tick
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_pos_clr    = 1'b0;
        w_pos_en     = 1'b0;
        w_hold_clr   = 1'b0;
        w_hold_en    = 1'b0;
        w_pass_clr   = 1'b0;
        w_pass_inc   = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_latch      = 1'b1;
                    w_pos_clr    = 1'b1;
                    w_pass_clr   = 1'b1;
                    w_state_next = ST_SCROLL;
                end
            end
            ST_SCROLL: begin
                if (i_abort) begin
                    w_pos_clr    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (i_start && (RESTART_EN != 0)) begin
                    w_latch      = 1'b1;
                    w_pos_clr    = 1'b1;
                    w_pass_clr   = 1'b1;
                    w_state_next = ST_SCROLL;
                end else if (i_scroll_tick) begin
                    if (w_pos_tc) begin
                        w_pos_clr  = 1'b1;
                        w_pass_inc = 1'b1;
                        if (r_pass_cnt == PASS_LAST) begin
                            if (HOLD_TICKS == 0) begin
                                w_state_next = ST_PUBLISH;
                            end else begin
                                w_hold_clr   = 1'b1;
                                w_state_next = ST_HOLD;
                            end
                        end
                    end else begin
                        w_pos_en = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (i_abort) begin
                    w_pos_clr    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (i_start && (RESTART_EN != 0)) begin
                    w_latch      = 1'b1;
                    w_pos_clr    = 1'b1;
                    w_pass_clr   = 1'b1;
                    w_state_next = ST_SCROLL;
                end else if (i_scroll_tick) begin
                    if (w_hold_tc) begin
                        w_state_next = ST_PUBLISH;
                    end else begin
                        w_hold_en = 1'b1;
                    end
                end
            end
            ST_PUBLISH: begin
                w_publish    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latched inputs, pass counter and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat      <= '0;
            r_len       <= '0;
            r_pass_cnt  <= '0;
            r_done      <= 1'b0;
            r_fin       <= FINAL_STATUS;
            r_valid     <= 1'b0;
            r_scrolling <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_latch) begin
                r_stat <= i_temp_gate_status;
                r_len  <= i_msg_len;
            end
            if (w_pass_clr) begin
                r_pass_cnt <= '0;
            end else if (w_pass_inc) begin
                r_pass_cnt <= r_pass_cnt + PASS_W'(1);
            end
            r_done <= w_publish;
            if (w_publish) begin
                r_fin   <= (PASS_THROUGH != 0) ? r_stat : FINAL_STATUS;
                r_valid <= 1'b1;
            end
            // Decoded from next state so these track the state register exactly
            r_scrolling <= (w_state_next == ST_SCROLL);
            r_busy      <= (w_state_next == ST_SCROLL) || (w_state_next == ST_HOLD);
        end
    end

    assign o_scroll_pos           = w_pos;
    assign o_scrolling            = r_scrolling;
    assign o_busy                 = r_busy;
    assign o_done                 = r_done;
    assign o_finished_gate_status = r_fin;
    assign o_status_valid         = r_valid;

endmodule

// File: tb/tb_scroll_status_sequencer.sv
// Self-checking bench: four parameter variants driven in lockstep against a tick-count reference model.
module tb_scroll_status_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] temp = 3'd0;
    logic [4:0] len = 5'd0;

    logic [4:0] o_pos  [4];
    logic       o_scr  [4];
    logic       o_busy [4];
    logic       o_done [4];
    logic [2:0] o_fin  [4];
    logic       o_valid[4];
    logic [11:0] w_obs [4];

    // Variants: 0 baseline, 1 pass-through, 2 two passes, 3 no hold + pass-through + no restart
    int unsigned cfg_passes[4] = '{1, 1, 2, 1};
    int unsigned cfg_hold  [4] = '{2, 2, 2, 0};
    bit          cfg_pt    [4] = '{0, 1, 0, 1};
    bit          cfg_rst   [4] = '{1, 1, 1, 0};

    // Reference model: ticks counted since accepted start
    bit          m_active[4];
    bit          m_pub   [4];
    int unsigned m_k     [4];
    int unsigned m_len   [4];
    logic [2:0]  m_stat  [4];
    bit          m_done  [4];
    logic [2:0]  m_fin   [4];
    bit          m_valid [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scroll_status_sequencer #(.PASSES(1), .HOLD_TICKS(2), .PASS_THROUGH(0), .RESTART_EN(1)) u_a (
        .i_clk(clk), .i_reset(reset), .i_scroll_tick(tick), .i_start(start), .i_abort(abort),
        .i_temp_gate_status(temp), .i_msg_len(len), .o_scroll_pos(o_pos[0]), .o_scrolling(o_scr[0]),
        .o_busy(o_busy[0]), .o_done(o_done[0]), .o_finished_gate_status(o_fin[0]), .o_status_valid(o_valid[0]));
    scroll_status_sequencer #(.PASSES(1), .HOLD_TICKS(2), .PASS_THROUGH(1), .RESTART_EN(1)) u_b (
        .i_clk(clk), .i_reset(reset), .i_scroll_tick(tick), .i_start(start), .i_abort(abort),
        .i_temp_gate_status(temp), .i_msg_len(len), .o_scroll_pos(o_pos[1]), .o_scrolling(o_scr[1]),
        .o_busy(o_busy[1]), .o_done(o_done[1]), .o_finished_gate_status(o_fin[1]), .o_status_valid(o_valid[1]));
    scroll_status_sequencer #(.PASSES(2), .HOLD_TICKS(2), .PASS_THROUGH(0), .RESTART_EN(1)) u_c (
        .i_clk(clk), .i_reset(reset), .i_scroll_tick(tick), .i_start(start), .i_abort(abort),
        .i_temp_gate_status(temp), .i_msg_len(len), .o_scroll_pos(o_pos[2]), .o_scrolling(o_scr[2]),
        .o_busy(o_busy[2]), .o_done(o_done[2]), .o_finished_gate_status(o_fin[2]), .o_status_valid(o_valid[2]));
    scroll_status_sequencer #(.PASSES(1), .HOLD_TICKS(0), .PASS_THROUGH(1), .RESTART_EN(0)) u_d (
        .i_clk(clk), .i_reset(reset), .i_scroll_tick(tick), .i_start(start), .i_abort(abort),
        .i_temp_gate_status(temp), .i_msg_len(len), .o_scroll_pos(o_pos[3]), .o_scrolling(o_scr[3]),
        .o_busy(o_busy[3]), .o_done(o_done[3]), .o_finished_gate_status(o_fin[3]), .o_status_valid(o_valid[3]));

    for (genvar g = 0; g < 4; g++) begin : g_obs
        assign w_obs[g] = {o_pos[g], o_scr[g], o_busy[g], o_done[g], o_fin[g], o_valid[g]};
    end

    // Expected packed outputs of variant i from the model
    function automatic logic [11:0] exp_of(input int i);
        int unsigned per;
        int unsigned scroll_total;
        logic        scr;
        logic [4:0]  pos;
        per          = m_len[i] + 4;
        scroll_total = cfg_passes[i] * per;
        scr          = m_active[i] && (m_k[i] < scroll_total);
        pos          = scr ? 5'(m_k[i] % per) : 5'd0;
        return {pos, scr, m_active[i], m_done[i], m_fin[i], m_valid[i]};
    endfunction

    // Advance the model by one clock using the currently applied inputs
    task automatic model_update();
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_active[i] = 0; m_pub[i] = 0; m_k[i] = 0;
                m_done[i] = 0; m_fin[i] = 3'd2; m_valid[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_pub[i]) begin
                    m_pub[i] = 0; m_done[i] = 1; m_valid[i] = 1;
                    m_fin[i] = cfg_pt[i] ? m_stat[i] : 3'd2;
                end else if (m_active[i] && abort) begin
                    m_active[i] = 0; m_k[i] = 0;
                end else if (start && (!m_active[i] || cfg_rst[i])) begin
                    m_active[i] = 1; m_k[i] = 0; m_len[i] = len; m_stat[i] = temp;
                end else if (m_active[i] && tick) begin
                    m_k[i]++;
                    if (m_k[i] == cfg_passes[i] * (m_len[i] + 4) + cfg_hold[i]) begin
                        m_active[i] = 0; m_pub[i] = 1;
                    end
                end
            end
        end
    endtask

    // One clock: drive pulses at negedge, update model at posedge, settle
    task automatic cycle(input logic rst, input logic tk, input logic st, input logic ab);
        @(negedge clk);
        reset = rst; tick = tk; start = st; abort = ab;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (w_obs[i] !== 12'b00000_0_0_0_010_0) begin
                n_errors++;
                $display("FAIL reset inst%0d got %h want %h", i, w_obs[i], 12'b00000_0_0_0_010_0);
            end
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_scroll_basic();
        len = 5'd5; temp = 3'd5;
        cycle(0, 0, 1, 0);
        for (int t = 1; t <= 11; t++) begin
            cycle(0, 1, 0, 0);
            n_checks++;
            if (o_pos[0] !== ((t < 9) ? 5'(t) : 5'd0)) begin
                n_errors++;
                $display("FAIL basic_pos tick %0d got %0d want %0d", t, o_pos[0], (t < 9) ? t : 0);
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (w_obs[i] !== exp_of(i)) begin
                    n_errors++;
                    $display("FAIL basic_lockstep inst%0d t=%0t got %h want %h", i, $time, w_obs[i], exp_of(i));
                end
            end
        end
        n_checks++;
        if (o_done[0] !== 1'b0) begin
            n_errors++; $display("FAIL basic_early_done got %b want 0", o_done[0]);
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if ({o_done[0], o_fin[0], o_valid[0], o_fin[1], o_done[1]} !== {1'b1, 3'd2, 1'b1, 3'd5, 1'b1}) begin
            n_errors++;
            $display("FAIL basic_publish got done=%b fin=%0d valid=%b finB=%0d doneB=%b want 1 2 1 5 1",
                     o_done[0], o_fin[0], o_valid[0], o_fin[1], o_done[1]);
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (o_done[0] !== 1'b0) begin
            n_errors++; $display("FAIL basic_done_pulse got %b want 0", o_done[0]);
        end
    endtask

    task automatic test_two_pass();
        int ticks = 0;
        int wraps = 0;
        logic [4:0] prev;
        len = 5'd3; temp = 3'd6;
        cycle(0, 0, 1, 0);
        prev = o_pos[2];
        while (o_busy[2] === 1'b1 && ticks < 60) begin
            cycle(0, 1, 0, 0);
            ticks++;
            if (prev == 5'd6 && o_pos[2] == 5'd0 && o_scr[2]) wraps++;
            prev = o_pos[2];
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (w_obs[i] !== exp_of(i)) begin
                    n_errors++;
                    $display("FAIL twopass_lockstep inst%0d t=%0t got %h want %h", i, $time, w_obs[i], exp_of(i));
                end
            end
        end
        n_checks++;
        if (ticks != 16) begin
            n_errors++; $display("FAIL twopass_ticks got %0d want 16", ticks);
        end
        n_checks++;
        if (wraps != 1) begin
            n_errors++; $display("FAIL twopass_wraps got %0d want 1", wraps);
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (o_done[2] !== 1'b1) begin
            n_errors++; $display("FAIL twopass_done got %b want 1", o_done[2]);
        end
        repeat (3) cycle(0, 0, 0, 0);
    endtask

    task automatic test_abort();
        int dones = 0;
        len = 5'd5; temp = 3'd1;
        cycle(0, 0, 1, 0);
        repeat (4) cycle(0, 1, 0, 0);
        n_checks++;
        if (o_pos[0] !== 5'd4) begin
            n_errors++; $display("FAIL abort_pre_pos got %0d want 4", o_pos[0]);
        end
        cycle(0, 1, 1, 1);
        n_checks++;
        if ({o_pos[0], o_busy[0], o_scr[0], o_fin[0], o_valid[0], o_fin[1]} !== {5'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd6}) begin
            n_errors++;
            $display("FAIL abort_state got pos=%0d busy=%b scr=%b fin=%0d valid=%b finB=%0d want 0 0 0 2 1 6",
                     o_pos[0], o_busy[0], o_scr[0], o_fin[0], o_valid[0], o_fin[1]);
        end
        repeat (12) begin
            cycle(0, 1, 0, 0);
            for (int i = 0; i < 4; i++) if (o_done[i]) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_errors++; $display("FAIL abort_no_done got %0d want 0", dones);
        end
    endtask

    task automatic test_restart();
        len = 5'd5; temp = 3'd5;
        cycle(0, 0, 1, 0);
        repeat (6) cycle(0, 1, 0, 0);
        temp = 3'd1;
        cycle(0, 0, 1, 0);
        n_checks++;
        if ({o_pos[0], o_scr[0], o_pos[3], o_scr[3]} !== {5'd0, 1'b1, 5'd6, 1'b1}) begin
            n_errors++;
            $display("FAIL restart_pos got posA=%0d scrA=%b posD=%0d scrD=%b want 0 1 6 1",
                     o_pos[0], o_scr[0], o_pos[3], o_scr[3]);
        end
        repeat (15) begin
            cycle(0, 1, 0, 0);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (w_obs[i] !== exp_of(i)) begin
                    n_errors++;
                    $display("FAIL restart_lockstep inst%0d t=%0t got %h want %h", i, $time, w_obs[i], exp_of(i));
                end
            end
        end
        repeat (2) cycle(0, 0, 0, 0);
        n_checks++;
        if ({o_fin[1], o_fin[3]} !== {3'd1, 3'd5}) begin
            n_errors++; $display("FAIL restart_status got finB=%0d finD=%0d want 1 5", o_fin[1], o_fin[3]);
        end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_reset_hold();
        len = 5'd5; temp = 3'd3;
        cycle(0, 0, 1, 0);
        repeat (10) cycle(0, 1, 0, 0);
        n_checks++;
        if ({o_busy[0], o_scr[0]} !== 2'b10) begin
            n_errors++; $display("FAIL hold_state got busy=%b scr=%b want 1 0", o_busy[0], o_scr[0]);
        end
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (w_obs[i] !== 12'b00000_0_0_0_010_0) begin
                n_errors++;
                $display("FAIL hold_reset inst%0d got %h want %h", i, w_obs[i], 12'b00000_0_0_0_010_0);
            end
        end
        len = 5'd0;
        cycle(0, 1, 1, 0);
        n_checks++;
        if ({o_pos[0], o_scr[0], o_busy[0]} !== {5'd0, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL start_tick got pos=%0d scr=%b busy=%b want 0 1 1", o_pos[0], o_scr[0], o_busy[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) len = 5'($urandom_range(0, 10));
            temp = 3'($urandom);
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 59) == 0));
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (w_obs[i] !== exp_of(i)) begin
                    n_errors++;
                    $display("FAIL random_lockstep inst%0d t=%0t got %h want %h", i, $time, w_obs[i], exp_of(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scroll_basic();
        test_two_pass();
        test_abort();
        test_restart();
        test_reset_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
